// File: rtl/frame_scheduler.sv
// Frame scheduler: paces game steps from the frame rate and arbitrates a
// single-port tile memory between the renderer (always wins) and game logic
// (only inside vertical blank while a step is active).
module frame_scheduler #(
    parameter int unsigned SPEED_DIV = 8,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        px,
    input  logic [8:0]        py,
    input  logic              pause,
    input  logic              render_req,
    input  logic [ADDR_W-1:0] render_addr,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    input  logic              game_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              game_gnt,
    output logic              render_rvalid,
    output logic              game_rvalid,
    output logic              step,
    output logic              step_active,
    output logic              overrun
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPEED_DIV - 1);
    localparam logic [8:0] VBLANK_LINE = 9'd480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic              r_step;
    logic              r_step_active;
    logic              r_overrun;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_rd_render;
    logic              r_rd_game;
    logic              r_render_rvalid;
    logic              r_game_rvalid;

    logic w_vblank;
    logic w_frame_start;
    logic w_vblank_end;
    logic w_game_gnt;
    logic w_unused;

    // Raster position decode
    assign w_vblank      = (py >= VBLANK_LINE);
    assign w_frame_start = (px == 10'd0) && (py == VBLANK_LINE);
    assign w_vblank_end  = (px == 10'd0) && (py == 9'd0);

    // Renderer has absolute priority; game only gets the memory in vblank during a step
    assign w_game_gnt = game_req & w_vblank & r_step_active & ~render_req;

    // Read data is consumed by the requesters directly, not by this block
    assign w_unused = ^mem_rdata;

    // Frame counter and step pulse generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_step      <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (w_frame_start && !pause) begin
                if (r_frame_cnt == CNT_LAST) begin
                    r_frame_cnt <= '0;
                    r_step      <= 1'b1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

    // Step FSM: IDLE -> ARMED on step, ARMED -> RUN on first grant, back to IDLE on done or vblank end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_step_active <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_step) begin
                        r_state       <= ST_ARMED;
                        r_step_active <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (w_vblank_end) begin
                        r_state       <= ST_IDLE;
                        r_step_active <= 1'b0;
                        r_overrun     <= 1'b1;
                    end else if (w_game_gnt) begin
                        r_state <= ST_RUN;
                    end
                    if (r_step) begin
                        r_overrun <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (game_done) begin
                        r_state       <= ST_IDLE;
                        r_step_active <= 1'b0;
                    end else if (w_vblank_end) begin
                        r_state       <= ST_IDLE;
                        r_step_active <= 1'b0;
                        r_overrun     <= 1'b1;
                    end
                    if (r_step) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_step_active <= 1'b0;
                end
            endcase
        end
    end

    // Registered memory command; address and write data hold when nothing is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= render_req | w_game_gnt;
            if (render_req) begin
                r_mem_we   <= 1'b0;
                r_mem_addr <= render_addr;
            end else if (w_game_gnt) begin
                r_mem_we    <= game_we;
                r_mem_addr  <= game_addr;
                r_mem_wdata <= game_wdata;
            end else begin
                r_mem_we <= 1'b0;
            end
        end
    end

    // Read ownership tags, aligned with mem_rdata one cycle after the command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_render     <= 1'b0;
            r_rd_game       <= 1'b0;
            r_render_rvalid <= 1'b0;
            r_game_rvalid   <= 1'b0;
        end else begin
            r_rd_render     <= render_req;
            r_rd_game       <= w_game_gnt & ~game_we;
            r_render_rvalid <= r_rd_render;
            r_game_rvalid   <= r_rd_game;
        end
    end

    assign mem_en        = r_mem_en;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign game_gnt      = w_game_gnt;
    assign render_rvalid = r_render_rvalid;
    assign game_rvalid   = r_game_rvalid;
    assign step          = r_step;
    assign step_active   = r_step_active;
    assign overrun       = r_overrun;

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter SPEED_DIV, default 8: frames per game step, legal range 1..255.
REQ-002 Parameter ADDR_W, default 10: tile memory address width (32x24 tile grid).
REQ-003 Parameter DATA_W, default 4: tile memory data width.
REQ-004 clk  in  1  pixel clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 px  in  10  current horizontal pixel position from the sync generator.
REQ-007 py  in  9  current vertical line position from the sync generator.
REQ-008 pause  in  1  high freezes frame counting.
REQ-009 render_req / render_addr  in  1 / ADDR_W  renderer tile read request.
REQ-010 game_req / game_we / game_addr / game_wdata  in  1 / 1 / ADDR_W / DATA_W  game-logic access request.
REQ-011 game_done  in  1  single-cycle pulse: game logic finished its step.
REQ-012 mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / ADDR_W / DATA_W  registered single-port memory command.
REQ-013 mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en.
REQ-014 game_gnt  out  1  combinational grant for game_req this cycle.
REQ-015 render_rvalid / game_rvalid  out  1 / 1  read data on mem_rdata belongs to that requester.
REQ-016 step  out  1  single-cycle pulse starting a game step.
REQ-017 step_active  out  1  game step in progress.
REQ-018 overrun  out  1  sticky: step not finished inside its vertical blank window.

Function
REQ-019 vblank SHALL be (py >= 480); frame_start SHALL be the cycle with px == 0 and py == 480.
REQ-020 8-bit frame counter SHALL increment on frame_start when pause is low, wrap from SPEED_DIV-1 to 0, and assert step in the cycle after the wrap frame_start.
REQ-021 FSM states IDLE, ARMED, RUN; IDLE->ARMED on step; ARMED->RUN on first game_gnt; RUN->IDLE on game_done; ARMED or RUN->IDLE with overrun set when px == 0 and py == 0 (vblank ends).
REQ-022 step_active SHALL be high in ARMED and RUN.
REQ-023 step arriving while ARMED or RUN SHALL set overrun and leave the state unchanged.
REQ-024 game_done in IDLE or ARMED SHALL be ignored.
REQ-025 Arbitration, per cycle: render_req wins unconditionally; otherwise game_gnt = game_req AND vblank AND step_active.
REQ-026 Granted request in cycle N SHALL appear on mem_en/mem_we/mem_addr/mem_wdata in cycle N+1; mem_we SHALL be 0 for render accesses.
REQ-027 No request granted in cycle N: mem_en and mem_we low in N+1; mem_addr and mem_wdata hold.
REQ-028 render_rvalid / game_rvalid SHALL assert in cycle N+2 for a granted read (game reads only, game_we = 0); never both high.
REQ-029 Ungranted game_req SHALL be held by the requester; the block stores no requests.
REQ-030 overrun SHALL clear only on reset.

Reset
REQ-031 rst_n low SHALL immediately clear: frame counter 0, FSM IDLE, step 0, step_active 0, overrun 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, both rvalid 0.
REQ-032 Reset mid-step SHALL abandon the step without asserting overrun; the first step after release comes at the SPEED_DIV-th frame_start.

Verification
REQ-033 SPEED_DIV=3, pause low, 7 frames -> step pulses after frame_start 3 and 6, exactly one cycle each.
REQ-034 ARMED in vblank, game_req with game_we=0 and addr 5, render_req low -> game_gnt same cycle, mem_en=1/mem_addr=5 next cycle, game_rvalid the cycle after.
REQ-035 render_req and game_req together in vblank while ARMED -> render granted, game_gnt 0, game access granted first free cycle after.
REQ-036 step issued, game_done never pulses -> at px=0 py=0 FSM returns IDLE, overrun=1, game_gnt stays 0 during visible lines.
REQ-037 pause high across 10 frame_starts -> counter frozen, no step; resumes from held value when pause drops.
REQ-038 rst_n pulsed low during RUN -> all outputs zero asynchronously, overrun 0, no step until 3rd frame_start (SPEED_DIV=3).
